wbm: RTL

Write-back/memory stage of the ECAP5-DPROC pipeline, directly downstream of the execute stage. Accepts the execute result, branch decision and optional load/store request through a ready/valid handshake. Performs at most one data-memory transaction over a req/ack port, then drives the register-file write port. Forwards the branch decision to fetch as a one-cycle pulse.

---
 rtl/ecap5_dproc_pkg.sv | 32 +++
 rtl/wbm_lane_align.sv | 58 +++++
 rtl/wbm.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// ============================================================================
//  Module      : ecap5_dproc_pkg
//  Description : Shared memory-size encodings, the write-back FSM state type
//                and the lane-offset helper used by the wbm stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecap5_dproc_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WB   = 2'd2
  } wbm_state_t;

  // Byte lane of the access; low address bits that cannot select a lane are dropped.
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] a);
    case (size)
      MEM_BYTE: return a;
      MEM_HALF: return {a[1], 1'b0};
      default:  return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/wbm_lane_align.sv
// ============================================================================
//  Module      : wbm_lane_align
//  Description : Combinational byte-lane steering: store lane enables and data
//                shift, load data shift and sign/zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbm_lane_align
  import ecap5_dproc_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_sel,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_addr,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [1:0]  w_st_lane;
  logic [1:0]  w_ld_lane;
  logic [31:0] w_ld_shift;
  logic        w_ld_sign;

  always_comb begin
    w_st_lane  = lane_offset(i_st_size, i_st_addr);
    o_st_wdata = i_st_wdata << {w_st_lane, 3'b000};
    case (i_st_size)
      MEM_BYTE: o_st_sel = 4'b0001 << w_st_lane;
      MEM_HALF: o_st_sel = 4'b0011 << w_st_lane;
      default:  o_st_sel = 4'b1111;
    endcase
  end

  always_comb begin
    w_ld_lane  = lane_offset(i_ld_size, i_ld_addr);
    w_ld_shift = i_rdata >> {w_ld_lane, 3'b000};
    w_ld_sign  = 1'b0;
    case (i_ld_size)
      MEM_BYTE: begin
        w_ld_sign = ~i_ld_unsigned & w_ld_shift[7];
        o_ld_data = {{24{w_ld_sign}}, w_ld_shift[7:0]};
      end
      MEM_HALF: begin
        w_ld_sign = ~i_ld_unsigned & w_ld_shift[15];
        o_ld_data = {{16{w_ld_sign}}, w_ld_shift[15:0]};
      end
      default:  o_ld_data = w_ld_shift;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wbm.sv
// ============================================================================
//  Module      : wbm
//  Description : ECAP5-DPROC write-back/memory stage; one optional data-memory
//                access per transfer, then a register-file write.
//                Optional misalignment trap: ECAP5_DPROC_MISALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wbm
  import ecap5_dproc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        input_valid_i,
  output logic        input_ready_o,
  input  logic        result_write_i,
  input  logic [4:0]  result_addr_i,
  input  logic [31:0] result_i,
  input  logic        branch_i,
  input  logic [19:0] branch_offset_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
`ifdef ECAP5_DPROC_MISALIGN_CHECK_EN
  output logic        misaligned_o,
`endif
  output logic        reg_write_o,
  output logic [4:0]  reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic        branch_o,
  output logic [19:0] branch_offset_o
);

  wbm_state_t  r_state;
  wbm_state_t  w_next_state;

  logic        r_is_load;
  logic        r_write;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_unsigned;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_go_mem;
  logic [3:0]  w_st_sel;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;

  assign input_ready_o = (r_state == IDLE);
  assign w_accept      = input_valid_i && input_ready_o;
  assign w_is_mem      = mem_read_i || mem_write_i;

`ifdef ECAP5_DPROC_MISALIGN_CHECK_EN
  assign w_misaligned  = ((mem_size_i == MEM_HALF) && result_i[0])
                      || (mem_size_i[1] && (result_i[1:0] != 2'b00));
`else
  assign w_misaligned  = 1'b0;
`endif

  assign w_go_mem = w_is_mem && !w_misaligned;

  wbm_lane_align u_lane_align (
    .i_st_size     (mem_size_i),
    .i_st_addr     (result_i[1:0]),
    .i_st_wdata    (mem_wdata_i),
    .o_st_sel      (w_st_sel),
    .o_st_wdata    (w_st_wdata),
    .i_ld_size     (r_size),
    .i_ld_addr     (r_lane),
    .i_ld_unsigned (r_unsigned),
    .i_rdata       (mem_rdata_i),
    .o_ld_data     (w_ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // A misaligned memory transfer stays in IDLE; only its trap pulse remains.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_go_mem)       w_next_state = MEM;
          else if (!w_is_mem) w_next_state = WB;
        end
      end
      MEM:     if (mem_ack_i) w_next_state = WB;
      WB:      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_is_load       <= 1'b0;
      r_write         <= 1'b0;
      r_size          <= MEM_BYTE;
      r_lane          <= 2'b00;
      r_unsigned      <= 1'b0;
      mem_req_o       <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= 32'd0;
      mem_sel_o       <= 4'd0;
      mem_wdata_o     <= 32'd0;
      reg_write_o     <= 1'b0;
      reg_addr_o      <= 5'd0;
      reg_data_o      <= 32'd0;
      branch_o        <= 1'b0;
      branch_offset_o <= 20'd0;
`ifdef ECAP5_DPROC_MISALIGN_CHECK_EN
      misaligned_o    <= 1'b0;
`endif
    end else begin
      branch_o    <= w_accept && branch_i;
      reg_write_o <= 1'b0;
`ifdef ECAP5_DPROC_MISALIGN_CHECK_EN
      misaligned_o <= w_accept && w_is_mem && w_misaligned;
`endif
      if (w_accept) begin
        branch_offset_o <= branch_offset_i;
        r_is_load       <= mem_read_i;
        r_write         <= result_write_i;
        r_size          <= mem_size_i;
        r_lane          <= result_i[1:0];
        r_unsigned      <= mem_unsigned_i;
        reg_addr_o      <= result_addr_i;
        if (w_go_mem) begin
          mem_req_o   <= 1'b1;
          mem_we_o    <= !mem_read_i;
          mem_addr_o  <= {result_i[31:2], 2'b00};
          mem_sel_o   <= w_st_sel;
          mem_wdata_o <= w_st_wdata;
        end else if (!w_is_mem) begin
          reg_write_o <= result_write_i && (result_addr_i != 5'd0);
          reg_data_o  <= result_i;
        end
      end
      if ((r_state == MEM) && mem_ack_i) begin
        mem_req_o   <= 1'b0;
        reg_write_o <= r_is_load && r_write && (reg_addr_o != 5'd0);
        if (r_is_load) reg_data_o <= w_ld_data;
      end
    end
  end

endmodule

`default_nettype wire
